// File: rtl/process_scheduler_if.sv
// rtl/process_scheduler_if.sv - CPU-side signal bundle of the round-robin process scheduler
// master = CPU/loader side, slave = scheduler.
interface process_scheduler_if #(
   parameter int ID_W = 3
);
   logic            enable;
   logic [31:0]     pc;
   logic            load_valid;
   logic [ID_W-1:0] load_id;
   logic [31:0]     load_pc;
   logic            io_block;
   logic            io_done;
   logic [ID_W-1:0] io_id;
   logic            proc_end;
   logic            switch_ctx;
   logic [31:0]     next_pc;
   logic [ID_W-1:0] cur_proc;
   logic            running;
   logic            idle;

   modport master (
      output enable, pc, load_valid, load_id, load_pc, io_block, io_done, io_id, proc_end,
      input  switch_ctx, next_pc, cur_proc, running, idle
   );

   modport slave (
      input  enable, pc, load_valid, load_id, load_pc, io_block, io_done, io_id, proc_end,
      output switch_ctx, next_pc, cur_proc, running, idle
   );
endinterface

// File: rtl/process_scheduler.sv
// rtl/process_scheduler.sv - round-robin process scheduler with quantum preemption
// Holds per-slot state and saved PC; issues a one-cycle context-switch pulse.
module process_scheduler #(
   parameter int N_PROC  = 8,
   parameter int QUANTUM = 16,
   parameter int ID_W    = 3
) (
   input logic                clock,
   input logic                reset,
   process_scheduler_if.slave bus
);
   localparam int CNT_W = $clog2(QUANTUM);

   typedef enum logic [1:0] {
      FREE    = 2'b00,
      READY   = 2'b01,
      RUNNING = 2'b10,
      BLOCKED = 2'b11
   } slotStateT;

   typedef enum logic [1:0] {
      IDLE,
      SELECT,
      DISPATCH,
      RUN
   } ctrlStateT;

   slotStateT        slotState [N_PROC];
   logic [31:0]      savedPc [N_PROC];
   ctrlStateT        state;
   ctrlStateT        nextState;
   logic [CNT_W-1:0] quantumCount;
   logic [ID_W-1:0]  selSlot;
   logic [ID_W-1:0]  pickSlot;
   logic [ID_W-1:0]  probe;
   logic             pickFound;
   logic             anyReady;
   logic             evtEnd;
   logic             evtBlock;
   logic             evtExpire;
   logic             evtAny;
   logic             switchCtx;
   logic [31:0]      nextPc;
   logic [ID_W-1:0]  curProc;
   logic             isRunning;

   always_comb begin
      anyReady = 1'b0;
      for (int i = 0; i < N_PROC; i++) begin
         if (slotState[i] == READY) anyReady = 1'b1;
      end
   end

   // Walk offsets from the far end down so the nearest READY slot after curProc wins;
   // offset N_PROC wraps back to curProc itself.
   always_comb begin
      pickFound = 1'b0;
      pickSlot  = curProc;
      probe     = curProc;
      for (int i = N_PROC; i >= 1; i--) begin
         probe = curProc + ID_W'(i);
         if (slotState[probe] == READY) begin
            pickFound = 1'b1;
            pickSlot  = probe;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      evtEnd    = 1'b0;
      evtBlock  = 1'b0;
      evtExpire = 1'b0;
      case (state)
         IDLE:     if (anyReady) nextState = SELECT;
         SELECT:   nextState = pickFound ? DISPATCH : IDLE;
         DISPATCH: nextState = RUN;
         RUN: begin
            if (bus.proc_end)      evtEnd = 1'b1;
            else if (bus.io_block) evtBlock = 1'b1;
            else if (bus.enable && quantumCount == CNT_W'(QUANTUM - 1)) evtExpire = 1'b1;
            if (evtEnd || evtBlock || evtExpire) nextState = SELECT;
         end
         default:  nextState = IDLE;
      endcase
   end

   assign evtAny = evtEnd | evtBlock | evtExpire;

   // Load, io_done and scheduler events can never hit the same slot in one cycle:
   // each requires a different current state of that slot.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_PROC; i++) begin
            slotState[i] <= FREE;
            savedPc[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < N_PROC; i++) begin
            if (bus.load_valid && bus.load_id == ID_W'(i) && slotState[i] == FREE) begin
               slotState[i] <= READY;
               savedPc[i]   <= bus.load_pc;
            end
            if (bus.io_done && bus.io_id == ID_W'(i) && slotState[i] == BLOCKED) begin
               slotState[i] <= READY;
            end
         end
         if (evtEnd) slotState[curProc] <= FREE;
         if (evtBlock) begin
            slotState[curProc] <= BLOCKED;
            savedPc[curProc]   <= bus.pc + 32'd1;
         end
         if (evtExpire) begin
            slotState[curProc] <= READY;
            savedPc[curProc]   <= bus.pc + 32'd1;
         end
         if (state == DISPATCH) slotState[selSlot] <= RUNNING;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         quantumCount <= '0;
         selSlot      <= '0;
         switchCtx    <= 1'b0;
         nextPc       <= '0;
         curProc      <= '0;
         isRunning    <= 1'b0;
      end else begin
         switchCtx <= 1'b0;
         if (state == SELECT && pickFound) selSlot <= pickSlot;
         if (state == DISPATCH) begin
            curProc      <= selSlot;
            nextPc       <= savedPc[selSlot];
            switchCtx    <= 1'b1;
            isRunning    <= 1'b1;
            quantumCount <= '0;
         end
         if (state == RUN) begin
            if (evtAny)          isRunning <= 1'b0;
            else if (bus.enable) quantumCount <= quantumCount + 1'b1;
         end
      end
   end

   assign bus.switch_ctx = switchCtx;
   assign bus.next_pc    = nextPc;
   assign bus.cur_proc   = curProc;
   assign bus.running    = isRunning;
   assign bus.idle       = (state == IDLE) && !anyReady;
endmodule

// File: tb/tb_process_scheduler.sv
// tb/tb_process_scheduler.sv - directed self-checking bench for process_scheduler
module tb_process_scheduler;
   localparam int N_PROC  = 8;
   localparam int QUANTUM = 16;
   localparam int ID_W    = 3;

   logic clock = 1'b0;
   logic reset;
   int   passCount = 0;
   int   checkCount = 0;

   process_scheduler_if #(.ID_W(ID_W)) bus ();

   process_scheduler #(
      .N_PROC (N_PROC),
      .QUANTUM(QUANTUM),
      .ID_W   (ID_W)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expectSwitch(input string tag, input logic [31:0] pcExp, input logic [ID_W-1:0] idExp);
      check({tag, ".switch"}, 32'(bus.switch_ctx), 32'd1);
      check({tag, ".next_pc"}, bus.next_pc, pcExp);
      check({tag, ".cur_proc"}, 32'(bus.cur_proc), 32'(idExp));
      check({tag, ".running"}, 32'(bus.running), 32'd1);
   endtask

   // Called just after the event edge: running drops, pulse arrives two edges later.
   task automatic afterEvent(input string tag, input logic [31:0] pcExp, input logic [ID_W-1:0] idExp);
      check({tag, ".runDrop"}, 32'(bus.running), 32'd0);
      tick();
      check({tag, ".noEarly"}, 32'(bus.switch_ctx), 32'd0);
      tick();
      expectSwitch(tag, pcExp, idExp);
   endtask

   task automatic runSlice(input logic [31:0] startPc, input int n);
      bus.enable = 1'b1;
      for (int i = 0; i < n; i++) begin
         bus.pc = startPc + 32'(i);
         tick();
      end
   endtask

   initial begin
      bus.enable     = 1'b0;
      bus.pc         = '0;
      bus.load_valid = 1'b0;
      bus.load_id    = '0;
      bus.load_pc    = '0;
      bus.io_block   = 1'b0;
      bus.io_done    = 1'b0;
      bus.io_id      = '0;
      bus.proc_end   = 1'b0;
      reset          = 1'b1;
      repeat (3) tick();
      check("rst.switch", 32'(bus.switch_ctx), 32'd0);
      check("rst.next_pc", bus.next_pc, 32'd0);
      check("rst.cur_proc", 32'(bus.cur_proc), 32'd0);
      check("rst.running", 32'(bus.running), 32'd0);
      check("rst.idle", 32'(bus.idle), 32'd1);
      reset = 1'b0;
      tick();
      check("rst.idleHeld", 32'(bus.idle), 32'd1);

      // single process: first dispatch latency, then re-selection of itself on expiry
      bus.load_valid = 1'b1;
      bus.load_id    = 3'd0;
      bus.load_pc    = 32'h20;
      tick();
      bus.load_valid = 1'b0;
      check("t1.idleLow", 32'(bus.idle), 32'd0);
      tick();
      check("t1.wait1", 32'(bus.switch_ctx), 32'd0);
      tick();
      check("t1.wait2", 32'(bus.switch_ctx), 32'd0);
      tick();
      expectSwitch("t1.first", 32'h20, 3'd0);
      bus.enable = 1'b1;
      bus.pc     = 32'h20;
      tick();
      check("t1.pulseOneCycle", 32'(bus.switch_ctx), 32'd0);
      runSlice(32'h21, 15);
      afterEvent("t1.requeue", 32'h30, 3'd0);

      // three processes in round-robin order
      bus.load_valid = 1'b1;
      bus.load_id    = 3'd1;
      bus.load_pc    = 32'h40;
      runSlice(32'h30, 1);
      bus.load_id    = 3'd2;
      bus.load_pc    = 32'h60;
      runSlice(32'h31, 1);
      bus.load_valid = 1'b0;
      runSlice(32'h32, 14);
      afterEvent("t2.s1", 32'h40, 3'd1);
      runSlice(32'h40, 16);
      afterEvent("t2.s2", 32'h60, 3'd2);
      runSlice(32'h60, 16);
      afterEvent("t2.s0", 32'h40, 3'd0);
      runSlice(32'h40, 16);
      afterEvent("t2.s1b", 32'h50, 3'd1);

      // I/O block of slot 1, wake-up and resume at pc+1
      runSlice(32'h50, 5);
      bus.io_block = 1'b1;
      bus.pc       = 32'h55;
      tick();
      bus.io_block = 1'b0;
      afterEvent("t3.blk", 32'h70, 3'd2);
      bus.io_done = 1'b1;
      bus.io_id   = 3'd1;
      runSlice(32'h70, 1);
      bus.io_done = 1'b0;
      runSlice(32'h71, 15);
      afterEvent("t3.s0", 32'h50, 3'd0);
      runSlice(32'h50, 16);
      afterEvent("t3.resume", 32'h56, 3'd1);

      // proc_end together with expiry, plus a same-cycle load that must be ignored
      runSlice(32'h56, 15);
      bus.proc_end   = 1'b1;
      bus.load_valid = 1'b1;
      bus.load_id    = 3'd1;
      bus.load_pc    = 32'h100;
      bus.pc         = 32'h65;
      tick();
      bus.proc_end   = 1'b0;
      bus.load_pc    = 32'h200;
      check("t4.runDrop", 32'(bus.running), 32'd0);
      tick();
      bus.load_valid = 1'b0;
      check("t4.noEarly", 32'(bus.switch_ctx), 32'd0);
      tick();
      expectSwitch("t4.s2", 32'h80, 3'd2);
      runSlice(32'h80, 16);
      afterEvent("t4.s0", 32'h60, 3'd0);
      runSlice(32'h60, 16);
      afterEvent("t4.reload", 32'h200, 3'd1);

      // drain to idle, then wake through io_done
      bus.proc_end = 1'b1;
      tick();
      bus.proc_end = 1'b0;
      afterEvent("t5.s2", 32'h90, 3'd2);
      bus.io_block = 1'b1;
      bus.pc       = 32'h90;
      tick();
      bus.io_block = 1'b0;
      afterEvent("t5.s0", 32'h70, 3'd0);
      bus.proc_end = 1'b1;
      tick();
      bus.proc_end = 1'b0;
      check("t5.runDrop", 32'(bus.running), 32'd0);
      tick();
      check("t5.idleEnter", 32'(bus.idle), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5.idle", 32'(bus.idle), 32'd1);
         check("t5.noPulse", 32'(bus.switch_ctx), 32'd0);
         check("t5.notRunning", 32'(bus.running), 32'd0);
      end
      bus.io_done = 1'b1;
      bus.io_id   = 3'd2;
      tick();
      bus.io_done = 1'b0;
      check("t5.idleLeave", 32'(bus.idle), 32'd0);
      tick();
      check("t5.wait1", 32'(bus.switch_ctx), 32'd0);
      tick();
      check("t5.wait2", 32'(bus.switch_ctx), 32'd0);
      tick();
      expectSwitch("t5.wake", 32'h91, 3'd2);

      // reset while in DISPATCH
      runSlice(32'h91, 16);
      tick();
      reset = 1'b1;
      #1;
      check("t6.switch", 32'(bus.switch_ctx), 32'd0);
      check("t6.cur_proc", 32'(bus.cur_proc), 32'd0);
      check("t6.idle", 32'(bus.idle), 32'd1);
      check("t6.running", 32'(bus.running), 32'd0);
      check("t6.next_pc", bus.next_pc, 32'd0);
      bus.enable = 1'b0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t6.noPulse", 32'(bus.switch_ctx), 32'd0);
         check("t6.idleHeld", 32'(bus.idle), 32'd1);
      end

      // saved PC wraps from FFFFFFFF to 0
      bus.load_valid = 1'b1;
      bus.load_id    = 3'd5;
      bus.load_pc    = 32'h1000;
      tick();
      bus.load_valid = 1'b0;
      tick();
      tick();
      tick();
      expectSwitch("t7.first", 32'h1000, 3'd5);
      bus.io_block = 1'b1;
      bus.enable   = 1'b1;
      bus.pc       = 32'hFFFF_FFFF;
      tick();
      bus.io_block = 1'b0;
      bus.enable   = 1'b0;
      tick();
      check("t7.idle", 32'(bus.idle), 32'd1);
      bus.io_done = 1'b1;
      bus.io_id   = 3'd5;
      tick();
      bus.io_done = 1'b0;
      tick();
      tick();
      tick();
      expectSwitch("t7.wrap", 32'h0, 3'd5);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
